// File: rtl/fp_add_issuer.sv
// Requester-side front end for fp_adder: issues one operand pair at a time, times the
// fixed adder latency, and buffers results in a small FIFO. Optional: FP_ADD_ISSUER_STATS_EN.
module fp_add_issuer #(
    parameter int LAT_NORM  = 4,
    parameter int LAT_EXC   = 2,
    parameter int RES_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_error,
    output logic [31:0] fa_a,
    output logic [31:0] fa_b,
    output logic        fa_data_valid,
    input  logic [31:0] fa_sum,
    input  logic        fa_error
`ifdef FP_ADD_ISSUER_STATS_EN
    ,
    output logic [31:0] stat_ops,
    output logic [31:0] stat_err
`endif
);

    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int LAT_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t             state;
    logic               is_exc;
    logic [LAT_W-1:0]   lat_cnt;
    logic [32:0]        mem [RES_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_next;
    logic [CNT_W-1:0]   count;
    logic               accept;
    logic               push;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RES_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: continuous assigns give every combinational output a value on every path, so no latch can form.
    assign in_ready  = !rst && (state == S_IDLE) && (count < CNT_W'(RES_DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign push      = (state == S_WAIT) && (lat_cnt == '0);
    assign pop       = out_valid && out_ready;
    assign rd_next   = ptr_inc(rd_ptr);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            fa_a          <= '0;
            fa_b          <= '0;
            fa_data_valid <= 1'b0;
            is_exc        <= 1'b0;
            lat_cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        fa_a          <= in_a;
                        fa_b          <= in_b;
                        is_exc        <= (in_a[30:23] == 8'hFF) || (in_b[30:23] == 8'hFF);
                        fa_data_valid <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    fa_data_valid <= 1'b0;
                    lat_cnt       <= is_exc ? LAT_W'(LAT_EXC - 1) : LAT_W'(LAT_NORM - 1);
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    // lat_cnt reaches zero exactly in fp_adder's result cycle
                    if (lat_cnt == '0) state <= S_IDLE;
                    else               lat_cnt <= lat_cnt - LAT_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: result storage is not reset; occupancy is tracked by count, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {fa_sum, fa_error};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_sum   <= '0;
            out_error <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= rd_next;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Output register tracks the FIFO head and holds its last value once empty
            if (pop) begin
                if (count > CNT_W'(1)) {out_sum, out_error} <= mem[rd_next];
                else if (push)         {out_sum, out_error} <= {fa_sum, fa_error};
            end else if (push && (count == '0)) begin
                {out_sum, out_error} <= {fa_sum, fa_error};
            end
        end
    end

`ifdef FP_ADD_ISSUER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops <= '0;
            stat_err <= '0;
        end else if (push) begin
            stat_ops <= stat_ops + 32'd1;
            if (fa_error) stat_err <= stat_err + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_issuer.sv
// Scoreboard bench for fp_add_issuer with a timed fp_adder model that presents a valid
// sum only in its result cycle. Stats ports are checked when FP_ADD_ISSUER_STATS_EN is set.
module tb_fp_add_issuer;

    localparam int LAT_NORM  = 4;
    localparam int LAT_EXC   = 2;
    localparam int RES_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_error;
    logic [31:0] fa_a;
    logic [31:0] fa_b;
    logic        fa_data_valid;
    logic [31:0] fa_sum = 32'hDEAD_BEEF;
    logic        fa_error = 1'b1;
`ifdef FP_ADD_ISSUER_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_err;
`endif

    fp_add_issuer #(.LAT_NORM(LAT_NORM), .LAT_EXC(LAT_EXC), .RES_DEPTH(RES_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_error    (out_error),
        .fa_a         (fa_a),
        .fa_b         (fa_b),
        .fa_data_valid(fa_data_valid),
        .fa_sum       (fa_sum),
        .fa_error     (fa_error)
`ifdef FP_ADD_ISSUER_STATS_EN
        ,
        .stat_ops     (stat_ops),
        .stat_err     (stat_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        err;
        int          acc;
        bit          lat_chk;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_last = -10;
    bit   head_seen = 1'b0;
    int   exp_ops = 0;
    int   exp_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, want, cyc);
        end
    endtask

    // Known fp_adder results for the operand pairs used here: {sum, error}
    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return {32'h40400000, 1'b0};
            64'h7F800000_3F800000: return {32'h7F800000, 1'b0};
            64'h7FC00000_3F800000: return {32'h7FFFFFFF, 1'b1};
            64'h3F800000_3F800000: return {32'h40000000, 1'b0};
            64'h00000000_00000000: return {32'h00000000, 1'b0};
            64'h40000000_40000000: return {32'h40800000, 1'b0};
            64'hBF800000_3F800000: return {32'h00000000, 1'b0};
            64'h40400000_3F800000: return {32'h40800000, 1'b0};
            default:               return {a ^ b ^ 32'h1234_5678, 1'b0};
        endcase
    endfunction

    function automatic bit exc_op(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    endfunction

    // fp_adder model: result valid only in issue cycle + latency, garbage otherwise
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [32:0] m_res;
    bit          m_pend = 1'b0;
    int          m_at = 0;

    always @(posedge clk) begin
        if (m_pend && cyc == m_at) m_pend = 1'b0;
        if (rst) begin
            m_pend = 1'b0;
        end else if (fa_data_valid) begin
            m_pend = 1'b1;
            m_a    = fa_a;
            m_b    = fa_b;
            m_res  = ref_add(fa_a, fa_b);
            m_at   = cyc + (exc_op(fa_a, fa_b) ? LAT_EXC : LAT_NORM);
        end
        cyc = cyc + 1;
        #1;
        if (m_pend && cyc == m_at) begin
            fa_sum   = m_res[32:1];
            fa_error = m_res[0];
        end else begin
            fa_sum   = 32'hDEAD_BEEF;
            fa_error = 1'b1;
        end
    end

    // Monitor: issue pulse, operand hold, and scoreboard compare/pop
    always @(negedge clk) begin
        if (!rst) begin
            check("fa_data_valid", fa_data_valid, cyc == acc_last);
            if (m_pend) begin
                check("fa_a_hold", fa_a, m_a);
                check("fa_b_hold", fa_b, m_b);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        if (sb[0].lat_chk) check("latency", cyc - sb[0].acc, sb[0].lat);
                    end
                    check("out_sum", out_sum, sb[0].sum);
                    check("out_error", out_error, sb[0].err);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input int budget);
        logic [32:0] r;
        bit          done;
        exp_t        e;
        done = 1'b0;
        r    = ref_add(a, b);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.sum     = r[32:1];
                e.err     = r[0];
                e.acc     = cyc + 1;
                e.lat_chk = (sb.size() == 0);
                e.lat     = (exc_op(a, b) ? LAT_EXC : LAT_NORM) + 1;
                sb.push_back(e);
                acc_last = cyc + 1;
                exp_ops++;
                if (r[0]) exp_err++;
                done = 1'b1;
            end
        end
        if (!done) check("accept_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        check("drain_left", sb.size(), 0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        head_seen = 1'b0;
        acc_last  = -10;
        exp_ops   = 0;
        exp_err   = 0;
    endtask

    logic [63:0] pairs [8] = '{
        64'h3F800000_40000000, 64'h7F800000_3F800000, 64'h7FC00000_3F800000,
        64'h3F800000_3F800000, 64'h00000000_00000000, 64'h40000000_40000000,
        64'hBF800000_3F800000, 64'h40400000_3F800000
    };
    bit stop_toggle = 1'b0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] p;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_fa_data_valid", fa_data_valid, 1'b0);
        check("rst_fa_a", fa_a, 32'h0);
        check("rst_fa_b", fa_b, 32'h0);
        check("rst_out_sum", out_sum, 32'h0);
        check("rst_out_error", out_error, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1'b1);

        // Directed ops: normal, infinity, NaN, zero sums
        out_ready = 1'b1;
        send(32'h3F800000, 32'h40000000, 20); drain(40);
        send(32'h7F800000, 32'h3F800000, 20); drain(40);
        send(32'h7FC00000, 32'h3F800000, 20); drain(40);
        send(32'h00000000, 32'h00000000, 20); drain(40);
        send(32'hBF800000, 32'h3F800000, 20); drain(40);

        // Backpressure: two results buffer, third pair waits for a pop
        out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 20);
        send(32'h40000000, 32'h40000000, 20);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a     = 32'h40400000;
        in_b     = 32'h3F800000;
        repeat (10) begin
            @(negedge clk);
            check("in_ready_full", in_ready, 1'b0);
        end
        check("out_valid_full", out_valid, 1'b1);
        check("full_count", sb.size(), 2);
        out_ready = 1'b1;
        send(32'h40400000, 32'h3F800000, 20);
        drain(60);

        // Reset in the middle of S_WAIT drops the in-flight op
        send(32'h40000000, 32'h40000000, 20);
        repeat (2) @(posedge clk);
        do_reset(2);
        @(negedge clk);
        check("in_ready_post_rst", in_ready, 1'b1);
        repeat (8) @(negedge clk);
        check("no_out_after_rst", out_valid, 1'b0);
        send(32'h3F800000, 32'h40000000, 20); drain(40);

        // Stats scenario: 3 normal ops and 1 NaN op from a clean reset
        do_reset(2);
        send(32'h3F800000, 32'h40000000, 20);
        send(32'h3F800000, 32'h3F800000, 20);
        send(32'h40000000, 32'h40000000, 20);
        send(32'h7FC00000, 32'h3F800000, 20);
        drain(60);
`ifdef FP_ADD_ISSUER_STATS_EN
        check("stat_ops_4", stat_ops, 32'd4);
        check("stat_err_1", stat_err, 32'd1);
`endif

        // Random mix with random consumer backpressure
        stop_toggle = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    p = pairs[$urandom_range(0, 7)];
                    send(p[63:32], p[31:0], 60);
                end
                stop_toggle = 1'b1;
            end
            begin
                while (!stop_toggle) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain(100);
`ifdef FP_ADD_ISSUER_STATS_EN
        check("stat_ops_total", stat_ops, exp_ops);
        check("stat_err_total", stat_err, exp_err);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
